axi4_lite_master_dual: RTL and testbench

- Parametrised AXI4-Lite master with independent, concurrent read and write engines.
- User side: valid/ready command ports with per-byte write strobes; registered completion results carrying response codes.
- Adds a per-engine watchdog timeout so a hung slave cannot stall the master.
- Sits between local control logic (register sequencers, CPU bridges) and the AXI4-Lite interconnect.

---
 rtl/axi4_lite_master_dual.sv | 246 ++++++++++++++++++++++++
 tb/tb_axi4_lite_master_dual.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master_dual.sv
// AXI4-Lite master with independent read and write engines.
// Each engine accepts one command at a time over a valid/ready port, runs a
// single AXI4-Lite transaction and reports completion as a one-cycle DONE
// pulse with registered result fields that hold until the next completion.
// A per-engine watchdog ends a transaction with SLVERR if the slave hangs.
// Ports:
//   ACLK, ARESET             clock, synchronous active-high reset
//   WR_CMD_* / WR_DONE ...   user write command and completion result
//   RD_CMD_* / RD_DONE ...   user read command and completion result
//   M_AW*, M_W*, M_B*        AXI4-Lite write channels
//   M_AR*, M_R*              AXI4-Lite read channels
module axi4_lite_master_dual #(
  parameter int ADDRESS        = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH/8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  WR_CMD_VALID,
  output logic                  WR_CMD_READY,
  input  logic [ADDRESS-1:0]    WR_CMD_ADDR,
  input  logic [DATA_WIDTH-1:0] WR_CMD_DATA,
  input  logic [STRB_WIDTH-1:0] WR_CMD_STRB,
  output logic                  WR_DONE,
  output logic [1:0]            WR_RESP,
  output logic                  WR_TIMEOUT,
  input  logic                  RD_CMD_VALID,
  output logic                  RD_CMD_READY,
  input  logic [ADDRESS-1:0]    RD_CMD_ADDR,
  output logic                  RD_DONE,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic [1:0]            RD_RESP,
  output logic                  RD_TIMEOUT,
  output logic [ADDRESS-1:0]    M_AWADDR,
  output logic                  M_AWVALID,
  input  logic                  M_AWREADY,
  output logic [DATA_WIDTH-1:0] M_WDATA,
  output logic [STRB_WIDTH-1:0] M_WSTRB,
  output logic                  M_WVALID,
  input  logic                  M_WREADY,
  input  logic [1:0]            M_BRESP,
  input  logic                  M_BVALID,
  output logic                  M_BREADY,
  output logic [ADDRESS-1:0]    M_ARADDR,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_RDATA,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RVALID,
  output logic                  M_RREADY
);
  // The watchdog fires at the end of the TIMEOUT_CYCLES-th busy cycle,
  // i.e. while the counter (0 in the first busy cycle) holds TIMEOUT_CYCLES-1.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic                 WDOG_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [1:0]           SLVERR   = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;
  logic [ADDRESS-1:0]    awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rd_data_q, rd_data_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic wr_done_q, wr_done_d, wr_to_q, wr_to_d, rd_done_q, rd_done_d, rd_to_q, rd_to_d;
  logic [1:0] wr_resp_q, wr_resp_d, rd_resp_q, rd_resp_d;
  logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic aw_hs, w_hs, b_hs, r_hs, wr_wdog, rd_wdog;

  assign WR_CMD_READY = (wstate_q == W_IDLE) && !ARESET;
  assign RD_CMD_READY = (rstate_q == R_IDLE) && !ARESET;

  assign aw_hs   = awvalid_q && M_AWREADY;
  assign w_hs    = wvalid_q && M_WREADY;
  assign b_hs    = (wstate_q == W_RESP) && bready_q && M_BVALID;
  assign r_hs    = (rstate_q == R_DATA) && rready_q && M_RVALID;
  assign wr_wdog = WDOG_EN && (wstate_q != W_IDLE) && (wcnt_q == CNT_LAST);
  assign rd_wdog = WDOG_EN && (rstate_q != R_IDLE) && (rcnt_q == CNT_LAST);

  // Write engine
  always_comb begin
    wstate_d  = wstate_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    wr_done_d = 1'b0;
    wr_resp_d = wr_resp_q;
    wr_to_d   = wr_to_q;
    wcnt_d    = wcnt_q;
    if (wstate_q != W_IDLE && wcnt_q != CNT_MAX) wcnt_d = wcnt_q + 1'b1;
    case (wstate_q)
      W_IDLE: if (WR_CMD_VALID) begin
        awaddr_d  = WR_CMD_ADDR;
        wdata_d   = WR_CMD_DATA;
        wstrb_d   = WR_CMD_STRB;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        wcnt_d    = '0;
        wstate_d  = W_ADDR;
      end
      W_ADDR: begin
        // AW and W retire independently; a dropped VALID marks its channel done.
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
          bready_d = 1'b1;
          wstate_d = W_RESP;
        end
      end
      W_RESP: if (b_hs) begin
        bready_d  = 1'b0;
        wr_resp_d = M_BRESP;
        wr_to_d   = 1'b0;
        wr_done_d = 1'b1;
        wstate_d  = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
    // A completing handshake in the same cycle beats the watchdog.
    if (wr_wdog && !b_hs) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      wr_resp_d = SLVERR;
      wr_to_d   = 1'b1;
      wr_done_d = 1'b1;
      wstate_d  = W_IDLE;
    end
  end

  // Read engine
  always_comb begin
    rstate_d  = rstate_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rd_data_d = rd_data_q;
    rd_resp_d = rd_resp_q;
    rd_done_d = 1'b0;
    rd_to_d   = rd_to_q;
    rcnt_d    = rcnt_q;
    if (rstate_q != R_IDLE && rcnt_q != CNT_MAX) rcnt_d = rcnt_q + 1'b1;
    case (rstate_q)
      R_IDLE: if (RD_CMD_VALID) begin
        araddr_d  = RD_CMD_ADDR;
        arvalid_d = 1'b1;
        rcnt_d    = '0;
        rstate_d  = R_ADDR;
      end
      R_ADDR: if (M_ARREADY) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        rstate_d  = R_DATA;
      end
      R_DATA: if (r_hs) begin
        rready_d  = 1'b0;
        rd_data_d = M_RDATA;
        rd_resp_d = M_RRESP;
        rd_to_d   = 1'b0;
        rd_done_d = 1'b1;
        rstate_d  = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
    if (rd_wdog && !r_hs) begin
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      rd_resp_d = SLVERR;
      rd_to_d   = 1'b1;
      rd_done_d = 1'b1;
      rstate_d  = R_IDLE;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      araddr_q  <= '0;
      rd_data_q <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      wr_to_q   <= 1'b0;
      rd_to_q   <= 1'b0;
      wr_resp_q <= '0;
      rd_resp_q <= '0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      araddr_q  <= araddr_d;
      rd_data_q <= rd_data_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
      wr_to_q   <= wr_to_d;
      rd_to_q   <= rd_to_d;
      wr_resp_q <= wr_resp_d;
      rd_resp_q <= rd_resp_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign M_AWADDR   = awaddr_q;
  assign M_AWVALID  = awvalid_q;
  assign M_WDATA    = wdata_q;
  assign M_WSTRB    = wstrb_q;
  assign M_WVALID   = wvalid_q;
  assign M_BREADY   = bready_q;
  assign M_ARADDR   = araddr_q;
  assign M_ARVALID  = arvalid_q;
  assign M_RREADY   = rready_q;
  assign WR_DONE    = wr_done_q;
  assign WR_RESP    = wr_resp_q;
  assign WR_TIMEOUT = wr_to_q;
  assign RD_DONE    = rd_done_q;
  assign RD_DATA    = rd_data_q;
  assign RD_RESP    = rd_resp_q;
  assign RD_TIMEOUT = rd_to_q;
endmodule

// File: tb/tb_axi4_lite_master_dual.sv
// Bench for axi4_lite_master_dual: directed commands against a configurable
// slave model; expected completions are queued at command accept and
// compared by a monitor whenever a DONE pulse appears.
module tb_axi4_lite_master_dual;
  logic        ACLK, ARESET;
  logic        WR_CMD_VALID, WR_CMD_READY, WR_DONE, WR_TIMEOUT;
  logic [31:0] WR_CMD_ADDR, WR_CMD_DATA;
  logic [3:0]  WR_CMD_STRB;
  logic [1:0]  WR_RESP;
  logic        RD_CMD_VALID, RD_CMD_READY, RD_DONE, RD_TIMEOUT;
  logic [31:0] RD_CMD_ADDR, RD_DATA;
  logic [1:0]  RD_RESP;
  logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
  logic [3:0]  M_WSTRB;
  logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
  logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
  logic [1:0]  M_BRESP, M_RRESP;

  axi4_lite_master_dual #(.ADDRESS(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .CNT_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .WR_CMD_VALID(WR_CMD_VALID), .WR_CMD_READY(WR_CMD_READY), .WR_CMD_ADDR(WR_CMD_ADDR),
    .WR_CMD_DATA(WR_CMD_DATA), .WR_CMD_STRB(WR_CMD_STRB), .WR_DONE(WR_DONE),
    .WR_RESP(WR_RESP), .WR_TIMEOUT(WR_TIMEOUT),
    .RD_CMD_VALID(RD_CMD_VALID), .RD_CMD_READY(RD_CMD_READY), .RD_CMD_ADDR(RD_CMD_ADDR),
    .RD_DONE(RD_DONE), .RD_DATA(RD_DATA), .RD_RESP(RD_RESP), .RD_TIMEOUT(RD_TIMEOUT),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  // READY asserts after *_dly cycles of VALID; R follows AR by one cycle;
  // B follows one cycle after both AW and W have been seen.
  int aw_dly = 0, w_dly = 0, ar_dly = 0;
  bit b_never = 0, r_never = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;
  int aw_cnt, w_cnt, ar_cnt;
  logic aw_seen, w_seen, bvalid_s, rvalid_s;
  logic [1:0]  bresp_s, rresp_s;
  logic [31:0] rdata_s;

  assign M_AWREADY = M_AWVALID && (aw_cnt >= aw_dly);
  assign M_WREADY  = M_WVALID && (w_cnt >= w_dly);
  assign M_ARREADY = M_ARVALID && (ar_cnt >= ar_dly);
  assign M_BVALID  = bvalid_s;
  assign M_BRESP   = bresp_s;
  assign M_RVALID  = rvalid_s;
  assign M_RRESP   = rresp_s;
  assign M_RDATA   = rdata_s;

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_seen <= 1'b0; w_seen <= 1'b0; bvalid_s <= 1'b0; rvalid_s <= 1'b0;
      bresp_s <= 2'b00; rresp_s <= 2'b00; rdata_s <= 32'h0;
    end else begin
      aw_cnt <= (M_AWVALID && !M_AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (M_WVALID && !M_WREADY) ? w_cnt + 1 : 0;
      ar_cnt <= (M_ARVALID && !M_ARREADY) ? ar_cnt + 1 : 0;
      if (M_AWVALID && M_AWREADY) aw_seen <= 1'b1;
      if (M_WVALID && M_WREADY) w_seen <= 1'b1;
      if (aw_seen && w_seen && !bvalid_s && !b_never) begin
        bvalid_s <= 1'b1; bresp_s <= bresp_cfg; aw_seen <= 1'b0; w_seen <= 1'b0;
      end
      if (bvalid_s && M_BREADY) bvalid_s <= 1'b0;
      if (M_ARVALID && M_ARREADY && !r_never) begin
        rvalid_s <= 1'b1; rdata_s <= rdata_cfg; rresp_s <= rresp_cfg;
      end
      if (rvalid_s && M_RREADY) rvalid_s <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0]  resp;
    logic        to;
    int          acc;       // cycle number of the accept cycle
    int          lat;       // DONE cycle minus accept cycle
    logic        chk_data;
    logic [31:0] data;
  } exp_t;
  exp_t wr_q[$];
  exp_t rd_q[$];
  exp_t we, re;

  always @(negedge ACLK) begin
    if (WR_DONE) begin
      if (wr_q.size() == 0) check("wr_done_unexpected", 64'd1, 64'd0);
      else begin
        we = wr_q.pop_front();
        check("wr_resp", WR_RESP, we.resp);
        check("wr_timeout", WR_TIMEOUT, we.to);
        check("wr_latency", cyc - we.acc, we.lat);
      end
    end
    if (RD_DONE) begin
      if (rd_q.size() == 0) check("rd_done_unexpected", 64'd1, 64'd0);
      else begin
        re = rd_q.pop_front();
        check("rd_resp", RD_RESP, re.resp);
        check("rd_timeout", RD_TIMEOUT, re.to);
        check("rd_latency", cyc - re.acc, re.lat);
        if (re.chk_data) check("rd_data", RD_DATA, re.data);
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic wr_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er, input int el, input bit push, output int acc);
    int n = 0;
    @(negedge ACLK);
    WR_CMD_VALID = 1'b1; WR_CMD_ADDR = a; WR_CMD_DATA = d; WR_CMD_STRB = s;
    while (!WR_CMD_READY && n < 50) begin @(negedge ACLK); n++; end
    acc = cyc;
    if (!WR_CMD_READY) check("wr_accept_bound", 64'd0, 64'd1);
    else if (push) wr_q.push_back(exp_t'{resp: er, to: 1'b0, acc: cyc, lat: el, chk_data: 1'b0, data: 32'h0});
    @(posedge ACLK); #1;
    WR_CMD_VALID = 1'b0;
  endtask

  task automatic rd_issue(input logic [31:0] a, input logic [1:0] er, input logic eto, input int el,
                          input logic chk, input logic [31:0] ed, output int acc);
    int n = 0;
    @(negedge ACLK);
    RD_CMD_VALID = 1'b1; RD_CMD_ADDR = a;
    while (!RD_CMD_READY && n < 50) begin @(negedge ACLK); n++; end
    acc = cyc;
    if (!RD_CMD_READY) check("rd_accept_bound", 64'd0, 64'd1);
    else rd_q.push_back(exp_t'{resp: er, to: eto, acc: cyc, lat: el, chk_data: chk, data: ed});
    @(posedge ACLK); #1;
    RD_CMD_VALID = 1'b0;
  endtask

  task automatic wait_wr_done();
    int n = 0;
    do begin @(negedge ACLK); n++; end while (!WR_DONE && n < 60);
    if (!WR_DONE) check("wr_done_bound", 64'd0, 64'd1);
  endtask

  task automatic wait_rd_done();
    int n = 0;
    do begin @(negedge ACLK); n++; end while (!RD_DONE && n < 60);
    if (!RD_DONE) check("rd_done_bound", 64'd0, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int wacc, racc, n;
    ARESET = 1'b1;
    WR_CMD_VALID = 1'b0; WR_CMD_ADDR = '0; WR_CMD_DATA = '0; WR_CMD_STRB = '0;
    RD_CMD_VALID = 1'b0; RD_CMD_ADDR = '0;
    repeat (3) @(negedge ACLK);
    check("reset_cmd_ready", {WR_CMD_READY, RD_CMD_READY}, 2'b00);
    check("reset_ctrl", {M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY,
                         WR_DONE, RD_DONE, WR_TIMEOUT, RD_TIMEOUT}, 9'h0);
    check("reset_payload", {M_AWADDR, M_WDATA, M_WSTRB, M_ARADDR, RD_DATA, WR_RESP, RD_RESP}, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("idle_cmd_ready", {WR_CMD_READY, RD_CMD_READY}, 2'b11);

    // 1: basic write, always-ready slave
    wr_issue(32'h10, 32'hDEADBEEF, 4'b0011, 2'b00, 4, 1'b1, wacc);
    @(negedge ACLK);
    check("t1_awaddr", M_AWADDR, 32'h10);
    check("t1_wdata", M_WDATA, 32'hDEADBEEF);
    check("t1_wstrb", M_WSTRB, 4'b0011);
    check("t1_valids", {M_AWVALID, M_WVALID}, 2'b11);
    wait_wr_done();

    // 2: AWREADY 3 cycles after WREADY, BRESP=OKAY+1
    aw_dly = 3; bresp_cfg = 2'b01;
    wr_issue(32'h14, 32'h0BADF00D, 4'hF, 2'b01, 7, 1'b1, wacc);
    @(negedge ACLK);
    check("t2_valids_c1", {M_AWVALID, M_WVALID}, 2'b11);
    @(negedge ACLK);
    check("t2_valids_c2", {M_AWVALID, M_WVALID}, 2'b10);
    wait_wr_done();
    aw_dly = 0;

    // 3: read with ARREADY delayed 2 cycles
    ar_dly = 2; rdata_cfg = 32'h12345678; rresp_cfg = 2'b00;
    rd_issue(32'h20, 2'b00, 1'b0, 5, 1'b1, 32'h12345678, racc);
    check("t3_araddr", M_ARADDR, 32'h20);
    wait_rd_done();
    check("t3_ready_at_done", RD_CMD_READY, 1'b1);
    @(negedge ACLK);
    check("t3_ready_after", {RD_CMD_READY, RD_DONE}, 2'b10);
    ar_dly = 0;

    // 4: simultaneous read and write
    bresp_cfg = 2'b11; rresp_cfg = 2'b01; rdata_cfg = 32'hA5A50040;
    fork
      begin wr_issue(32'h44, 32'h00440044, 4'b1100, 2'b11, 4, 1'b1, wacc); wait_wr_done(); end
      begin rd_issue(32'h40, 2'b01, 1'b0, 3, 1'b1, 32'hA5A50040, racc); wait_rd_done(); end
    join
    check("t4_same_accept", wacc, racc);
    @(negedge ACLK);

    // 5: hung read -> watchdog, then a normal read
    r_never = 1'b1;
    rd_issue(32'h30, 2'b10, 1'b1, 9, 1'b0, 32'h0, racc);
    wait_rd_done();
    @(negedge ACLK);
    check("t5_rready_after_to", {M_RREADY, M_ARVALID}, 2'b00);
    r_never = 1'b0; rdata_cfg = 32'hCAFEF00D; rresp_cfg = 2'b00;
    rd_issue(32'h50, 2'b00, 1'b0, 3, 1'b1, 32'hCAFEF00D, racc);
    wait_rd_done();

    // 6: reset while waiting for B; the write is abandoned without DONE
    b_never = 1'b1;
    wr_issue(32'h60, 32'h11223344, 4'hF, 2'b00, 0, 1'b0, wacc);
    n = 0;
    while (!M_BREADY && n < 20) begin @(negedge ACLK); n++; end
    check("t6_reached_wresp", M_BREADY, 1'b1);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("t6_bready_in_reset", {M_BREADY, WR_CMD_READY}, 2'b00);
    ARESET = 1'b0; b_never = 1'b0;
    @(negedge ACLK);
    check("t6_ready_after_reset", WR_CMD_READY, 1'b1);
    repeat (12) @(negedge ACLK);

    check("wr_queue_drained", wr_q.size(), 0);
    check("rd_queue_drained", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
